core_exu_pipe: RTL and testbench
================================

CORE_EXU_PIPE -- requirements
Module: core_exu_pipe

Interface
Parameters:
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, data-memory address width, ADDR_W <= XLEN.
REQ-003 SHALL have parameter OUT_BUF, default 1, output skid-buffer enable; 0 = registered result only.
Ports:
REQ-004 SHALL have port clk, input, 1, single clock; rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid_i, input, 1, operation offered.
REQ-007 SHALL have port in_ready_o, output, 1, operation accepted when high with in_valid_i.
REQ-008 SHALL have ports alu_op_i, input, `ALU_OP_WIDTH, operation code from defines.vh; s1_i and s2_i, input, XLEN each, operands.
REQ-009 SHALL have port is_loadstore_i, input, 1, selects memory path; address = ALU ADD(s1_i, s2_i).
REQ-010 SHALL have ports mem_req_o, output, 1, and mem_gnt_i, input, 1, memory request handshake.
REQ-011 SHALL have ports mem_we_o, output, 1; mem_be_o, output, XLEN/8, byte enables; mem_addr_o, output, ADDR_W; mem_wdata_o, output, XLEN, lane-aligned store data.
REQ-012 SHALL have ports mem_rvalid_i, input, 1, and mem_rdata_i, input, XLEN, load response.
REQ-013 SHALL have ports out_valid_o, output, 1; out_ready_i, input, 1; d_o, output, XLEN, result; misalign_o, output, 1, result-qualifying fault flag.

Function
REQ-014 SHALL implement FSM IDLE, EXEC, MEM_REQ, MEM_WAIT, MUL, HOLD.
REQ-015 SHALL assert in_ready_o only in IDLE, or in HOLD when out_ready_i is high and OUT_BUF=1.
REQ-016 SHALL latch op/operands on accept; ALU op -> EXEC, result valid the next cycle (latency 1).
REQ-017 SHALL, for loadstore, compute the address in EXEC, then go to MEM_REQ holding mem_req_o and all mem_* outputs stable until mem_gnt_i.
REQ-018 SHALL complete stores on grant (-> HOLD, d_o = 0); loads go to MEM_WAIT until mem_rvalid_i.
REQ-019 SHALL sign- or zero-extend load data per LB/LH/LW/LBU/LHU (LD/LWU if XLEN=64) from the addressed byte lane.
REQ-020 SHALL detect misaligned half/word/double access in EXEC: no mem_req_o, misalign_o=1, d_o = faulting address, -> HOLD.
REQ-021 SHALL hold out_valid_o, d_o and misalign_o stable in HOLD until out_ready_i; then -> IDLE, or -> EXEC/MUL if a new op is accepted that cycle.
REQ-022 SHALL ignore mem_rvalid_i outside MEM_WAIT and mem_gnt_i outside MEM_REQ.
REQ-023 SHALL perform all arithmetic modulo 2^XLEN; shifts use the low log2(XLEN) bits of s2.

Reset
REQ-024 SHALL, on rst_n low, asynchronously enter IDLE with in_ready_o=0 during reset and in_ready_o=1 after release; out_valid_o, mem_req_o, mem_we_o, misalign_o = 0; mem_be_o, mem_addr_o, mem_wdata_o, d_o = 0.
REQ-025 SHALL abandon any in-flight operation on reset, including a pending mem_req_o, without waiting for grant.

Configuration
REQ-026 SHALL compile an iterative multiplier when macro CORE_EXU_MUL_EN is defined: MUL/MULH/MULHU/MULHSU enter MUL, one radix-2 step per cycle, result XLEN+1 cycles after accept.
REQ-027 SHALL, without CORE_EXU_MUL_EN, treat MUL-class op codes as ADD with latency 1 and instantiate no multiplier state.

Verification
REQ-028 SHALL verify ADD s1=0x7FFFFFFF, s2=1 -> out_valid_o one cycle after accept, d_o=0x80000000.
REQ-029 SHALL verify LB, address 0x103, mem_gnt_i after 3 stall cycles, rdata=0x80FFFFFF -> mem_addr_o stable through stall, d_o=0xFFFFFF80.
REQ-030 SHALL verify SH, address 0x101 -> no mem_req_o, misalign_o=1, d_o=0x101.
REQ-031 SHALL verify SB, address 0x102, s2_i=0xAB -> mem_be_o=4'b0100, mem_wdata_o=0x00AB0000, mem_we_o=1.
REQ-032 SHALL verify out_ready_i low for 5 cycles with back-to-back ops -> d_o held, in_ready_o low until drain, no op lost.
REQ-033 SHALL verify reset asserted during MEM_REQ -> mem_req_o=0 immediately; with CORE_EXU_MUL_EN, MUL 0xFFFFFFFF*2 -> d_o=0xFFFFFFFE after 33 cycles.

Source files
------------

// File: rtl/core_exu_pipe.sv
// Single-issue execute unit: ALU, load/store with a valid/ready result port.
// Define CORE_EXU_MUL_EN to build the iterative radix-2 multiplier (MUL/MULH/MULHSU/MULHU).
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif

module core_exu_pipe #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int OUT_BUF = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [`ALU_OP_WIDTH-1:0] alu_op_i,
    input  logic [XLEN-1:0]          s1_i,
    input  logic [XLEN-1:0]          s2_i,
    input  logic                     is_loadstore_i,
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    output logic                     mem_we_o,
    output logic [XLEN/8-1:0]        mem_be_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [XLEN-1:0]          mem_wdata_o,
    input  logic                     mem_rvalid_i,
    input  logic [XLEN-1:0]          mem_rdata_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          d_o,
    output logic                     misalign_o
);
    localparam int NB  = XLEN / 8;
    localparam int LW  = $clog2(NB);
    localparam int SW  = $clog2(XLEN);
    localparam int OPW = `ALU_OP_WIDTH;

    // ALU codes; memory codes are 1_S_U_SZ (S=store, U=zero-extend, SZ=log2 bytes)
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(5);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(7);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(8);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(9);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_MUL, S_HOLD
    } state_t;

    state_t              r_state;
    logic [OPW-1:0]      r_op;
    logic [XLEN-1:0]     r_s1, r_s2;
    logic                r_ls;
    logic                r_out_valid, r_mis;
    logic [XLEN-1:0]     r_d;
    logic                r_mem_req, r_mem_we;
    logic [NB-1:0]       r_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [XLEN-1:0]     r_mem_wdata;

    logic                w_accept, w_is_mul, w_mul_done;
    logic [XLEN-1:0]     w_mul_res;
    logic [XLEN-1:0]     w_sum, w_alu, w_rsh, w_ld, w_wmask, w_wdata;
    logic [SW-1:0]       w_shamt;
    logic [LW-1:0]       w_lane;
    logic [1:0]          w_size;
    logic                w_store, w_uns, w_misal;
    logic [NB-1:0]       w_be_base, w_be;

    assign in_ready_o = rst_n & ((r_state == S_IDLE) |
                                 ((r_state == S_HOLD) & out_ready_i & (OUT_BUF != 0)));
    assign w_accept   = in_valid_i & in_ready_o;

    assign w_sum   = r_s1 + r_s2;
    assign w_shamt = r_s2[SW-1:0];
    assign w_lane  = w_sum[LW-1:0];
    assign w_store = r_op[3];
    assign w_uns   = r_op[2];
    // Doubleword accesses only exist on a 64-bit datapath; narrow them to word otherwise
    assign w_size  = (XLEN == 32 && r_op[1:0] == 2'd3) ? 2'd2 : r_op[1:0];

    always_comb begin
        w_alu = r_s1 + r_s2;
        case (r_op)
            OP_SUB:  w_alu = r_s1 - r_s2;
            OP_AND:  w_alu = r_s1 & r_s2;
            OP_OR:   w_alu = r_s1 | r_s2;
            OP_XOR:  w_alu = r_s1 ^ r_s2;
            OP_SLL:  w_alu = r_s1 << w_shamt;
            OP_SRL:  w_alu = r_s1 >> w_shamt;
            OP_SRA:  w_alu = $signed(r_s1) >>> w_shamt;
            OP_SLT:  w_alu = XLEN'($signed(r_s1) < $signed(r_s2));
            OP_SLTU: w_alu = XLEN'(r_s1 < r_s2);
            default: w_alu = r_s1 + r_s2;
        endcase
    end

    always_comb begin
        w_misal   = 1'b0;
        w_be_base = NB'(8'hFF);
        w_wmask   = '1;
        case (w_size)
            2'd0: begin w_be_base = NB'(1); w_wmask = XLEN'(8'hFF); end
            2'd1: begin w_misal = w_sum[0]; w_be_base = NB'(3); w_wmask = XLEN'(16'hFFFF); end
            2'd2: begin w_misal = |w_sum[1:0]; w_be_base = NB'(8'h0F); w_wmask = XLEN'(32'hFFFF_FFFF); end
            default: w_misal = |w_sum[2:0];
        endcase
    end

    assign w_be    = w_be_base << w_lane;
    assign w_wdata = (r_s2 & w_wmask) << {w_lane, 3'b000};
    assign w_rsh   = mem_rdata_i >> {w_lane, 3'b000};

    always_comb begin
        case (w_size)
            2'd0:    w_ld = w_uns ? XLEN'(w_rsh[7:0])  : XLEN'($signed(w_rsh[7:0]));
            2'd1:    w_ld = w_uns ? XLEN'(w_rsh[15:0]) : XLEN'($signed(w_rsh[15:0]));
            2'd2:    w_ld = w_uns ? XLEN'(w_rsh[31:0]) : XLEN'($signed(w_rsh[31:0]));
            default: w_ld = w_rsh;
        endcase
    end

`ifdef CORE_EXU_MUL_EN
    // Shift-add on magnitudes: prod = {acc, multiplier}, one bit retired per cycle
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_mcand;
    logic              r_neg, r_hi;
    logic [SW:0]       r_cnt;
    logic              w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [XLEN:0]     w_step;
    logic [2*XLEN-1:0] w_prod_f;

    assign w_is_mul   = !is_loadstore_i && (alu_op_i[OPW-1:2] == 3'b011);
    assign w_a_neg    = s1_i[XLEN-1] && (alu_op_i[1:0] == 2'd1 || alu_op_i[1:0] == 2'd2);
    assign w_b_neg    = s2_i[XLEN-1] && (alu_op_i[1:0] == 2'd1);
    assign w_a_mag    = w_a_neg ? -s1_i : s1_i;
    assign w_b_mag    = w_b_neg ? -s2_i : s2_i;
    assign w_step     = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_f   = r_neg ? -r_prod : r_prod;
    assign w_mul_done = (r_cnt == (SW+1)'(XLEN));
    assign w_mul_res  = r_hi ? w_prod_f[2*XLEN-1:XLEN] : w_prod_f[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod  <= '0;
            r_mcand <= '0;
            r_neg   <= 1'b0;
            r_hi    <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept && w_is_mul) begin
            r_prod  <= {{XLEN{1'b0}}, w_b_mag};
            r_mcand <= w_a_mag;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_hi    <= (alu_op_i[1:0] != 2'd0);
            r_cnt   <= '0;
        end else if (r_state == S_MUL && !w_mul_done) begin
            r_prod  <= {w_step, r_prod[XLEN-1:1]};
            r_cnt   <= r_cnt + (SW+1)'(1);
        end
    end
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_res  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_ls        <= 1'b0;
            r_out_valid <= 1'b0;
            r_mis       <= 1'b0;
            r_d         <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (r_state == S_HOLD && out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_mis       <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                    if (w_accept) begin
                        r_op    <= alu_op_i;
                        r_s1    <= s1_i;
                        r_s2    <= s2_i;
                        r_ls    <= is_loadstore_i;
                        r_state <= w_is_mul ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!r_ls) begin
                        r_d         <= w_alu;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else if (w_misal) begin
                        r_d         <= XLEN'(w_sum[ADDR_W-1:0]);
                        r_mis       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_store;
                        r_mem_be    <= w_be;
                        r_mem_addr  <= w_sum[ADDR_W-1:0];
                        r_mem_wdata <= w_store ? w_wdata : '0;
                        r_state     <= S_MEM_REQ;
                    end
                end
                S_MEM_REQ: begin
                    if (mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_mem_we) begin
                            r_d         <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end else begin
                            r_state <= S_MEM_WAIT;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_d         <= w_ld;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                S_MUL: begin
                    if (w_mul_done) begin
                        r_d         <= w_mul_res;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid_o = r_out_valid;
    assign d_o         = r_d;
    assign misalign_o  = r_mis;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_core_exu_pipe.sv
// Scoreboard bench for core_exu_pipe: ALU, loads/stores with stalls, misalign,
// output backpressure, reset during a memory request, and the optional multiplier.
`timescale 1ns/1ps
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif

module tb_core_exu_pipe;
    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_MUL = 5'd12, OP_MULH = 5'd13;
    localparam logic [4:0] OP_MULHSU = 5'd14, OP_MULHU = 5'd15;
    localparam logic [4:0] OP_LB = 5'd16, OP_LH = 5'd17, OP_LW = 5'd18, OP_LBU = 5'd20, OP_LHU = 5'd21;
    localparam logic [4:0] OP_SB = 5'd24, OP_SH = 5'd25;
    localparam logic [4:0] ALU_OPS [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                                            5'd7, 5'd8, 5'd9, 5'd12, 5'd13, 5'd14, 5'd15};

    typedef struct packed { logic [31:0] d; logic mis; } exp_t;

    logic gclk = 1'b0, grst_n = 1'b0;
    always #5 gclk = ~gclk;

    logic                     in_valid, in_ready_o, is_ls;
    logic [`ALU_OP_WIDTH-1:0] alu_op;
    logic [31:0]              s1, s2;
    logic                     mem_req_o, mem_gnt, mem_we_o, mem_rvalid;
    logic [3:0]               mem_be_o;
    logic [31:0]              mem_addr_o, mem_wdata_o, mem_rdata;
    logic                     out_valid_o, out_ready, misalign_o;
    logic [31:0]              d_o;

    core_exu_pipe dut (
        .clk(gclk), .rst_n(grst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .alu_op_i(alu_op), .s1_i(s1), .s2_i(s2), .is_loadstore_i(is_ls),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .d_o(d_o), .misalign_o(misalign_o)
    );

    exp_t        sb_q[$];
    int          n_vec = 0, n_err = 0, n_pop = 0, req_cyc = 0;
    int          gnt_delay = 0;
    logic [31:0] mem_rd = '0;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = '0;
        case (op)
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return 32'($signed(a) >>> b[4:0]);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
`ifdef CORE_EXU_MUL_EN
            OP_MUL:    return a * b;
            OP_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            OP_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
            OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
`endif
            default: return a + b;
        endcase
    endfunction

    always @(posedge gclk) if (mem_req_o) req_cyc++;

    // Result monitor: a transfer happens on the next rising edge
    always @(negedge gclk) begin
        exp_t e;
        if (grst_n && out_valid_o && out_ready) begin
            if (sb_q.size() == 0) chk("unexpected_out", out_valid_o, 0);
            else begin
                e = sb_q.pop_front();
                chk("d_o", d_o, e.d);
                chk("misalign_o", misalign_o, e.mis);
                n_pop++;
            end
        end
    end

    // Memory responder with programmable grant stall
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge gclk); #1;
            if (grst_n && mem_req_o) begin
                cap_addr = mem_addr_o; cap_be = mem_be_o; cap_we = mem_we_o; cap_wdata = mem_wdata_o;
                for (int k = 0; k < gnt_delay; k++) begin
                    @(posedge gclk); #1;
                    if (!grst_n || !mem_req_o) break;
                    chk("addr_stable", mem_addr_o, cap_addr);
                    chk("wdata_stable", mem_wdata_o, cap_wdata);
                end
                if (grst_n && mem_req_o) begin
                    mem_gnt = 1'b1;
                    @(posedge gclk); #1;
                    mem_gnt = 1'b0;
                    if (!cap_we) begin
                        mem_rdata = mem_rd; mem_rvalid = 1'b1;
                        @(posedge gclk); #1;
                        mem_rvalid = 1'b0; mem_rdata = '0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ls, input logic push, input logic [31:0] ed, input logic em);
        int   w;
        exp_t e;
        alu_op = op; s1 = a; s2 = b; is_ls = ls; in_valid = 1'b1;
        w = 0;
        forever begin
            @(negedge gclk);
            if (in_ready_o) break;
            w++;
            if (w > 100) begin chk("accept_timeout", in_ready_o, 1); break; end
        end
        if (in_ready_o && push) begin e.d = ed; e.mis = em; sb_q.push_back(e); end
        @(posedge gclk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 500) begin @(posedge gclk); #1; w++; end
        chk("drain", sb_q.size(), 0);
        repeat (2) @(posedge gclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, p0, n;
        in_valid = 1'b0; alu_op = '0; s1 = '0; s2 = '0; is_ls = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_misalign", misalign_o, 0);
        chk("rst_be", mem_be_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_d", d_o, 0);
        repeat (3) @(posedge gclk);
        #3 grst_n = 1'b1;
        @(posedge gclk); #1;
        chk("ready_after_rst", in_ready_o, 1);

        // ADD overflow wraps, result one cycle after accept
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b0);
        chk("add_not_early", out_valid_o, 0);
        @(posedge gclk); #1;
        chk("add_latency", out_valid_o, 1);
        drain();

        for (int i = 0; i < 24; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = ALU_OPS[$urandom_range(0, 13)];
            a  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            b  = (i % 3 == 0) ? 32'hFFFF_FFFF : $urandom;
            issue(op, a, b, 1'b0, 1'b1, ref_alu(op, a, b), 1'b0);
        end
        drain();

        // LB with 3 stall cycles before grant
        gnt_delay = 3; mem_rd = 32'h80FF_FFFF;
        issue(OP_LB, 32'h100, 32'd3, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b0);
        drain();
        chk("lb_addr", cap_addr, 32'h103);
        chk("lb_be", cap_be, 4'b1000);
        chk("lb_we", cap_we, 0);
        gnt_delay = 0;
        mem_rd = 32'h8001_2345;
        issue(OP_LH, 32'h100, 32'd2, 1'b1, 1'b1, 32'hFFFF_8001, 1'b0);
        drain();
        issue(OP_LHU, 32'h100, 32'd2, 1'b1, 1'b1, 32'h0000_8001, 1'b0);
        drain();
        mem_rd = 32'h0000_9A00;
        issue(OP_LBU, 32'h100, 32'd1, 1'b1, 1'b1, 32'h0000_009A, 1'b0);
        drain();
        mem_rd = 32'hDEAD_BEEF;
        issue(OP_LW, 32'h100, 32'd4, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        drain();

        // Misaligned accesses fault without touching memory
        r0 = req_cyc;
        issue(OP_SH, 32'h100, 32'd1, 1'b1, 1'b1, 32'h101, 1'b1);
        drain();
        issue(OP_LW, 32'h100, 32'd2, 1'b1, 1'b1, 32'h102, 1'b1);
        drain();
        chk("misalign_no_req", req_cyc, r0);

        issue(OP_SB, 32'h57, 32'hAB, 1'b1, 1'b1, 32'd0, 1'b0);
        drain();
        chk("sb_addr", cap_addr, 32'h102);
        chk("sb_be", cap_be, 4'b0100);
        chk("sb_wdata", cap_wdata, 32'h00AB_0000);
        chk("sb_we", cap_we, 1);
        gnt_delay = 2;
        issue(OP_SH, 32'h1_0001, 32'h1235, 1'b1, 1'b1, 32'd0, 1'b0);
        drain();
        chk("sh_be", cap_be, 4'b1100);
        chk("sh_wdata", cap_wdata, 32'h1235_0000);
        gnt_delay = 0;

        // Backpressure: result held 5 cycles, following ops wait, none lost
        p0 = n_pop;
        out_ready = 1'b0;
        fork
            begin
                issue(OP_ADD, 32'd10, 32'd20, 1'b0, 1'b1, 32'd30, 1'b0);
                issue(OP_SUB, 32'd100, 32'd1, 1'b0, 1'b1, 32'd99, 1'b0);
                issue(OP_XOR, 32'hF0F0, 32'h0FF0, 1'b0, 1'b1, 32'hFF00, 1'b0);
            end
            begin
                int w;
                w = 0;
                while (!out_valid_o && w < 50) begin @(posedge gclk); #1; w++; end
                chk("bp_valid", out_valid_o, 1);
                repeat (5) begin
                    chk("bp_hold_d", d_o, 32'd30);
                    chk("bp_ready_low", in_ready_o, 0);
                    @(posedge gclk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", n_pop - p0, 3);

        // Reset while a request waits for grant
        gnt_delay = 20;
        issue(OP_LW, 32'h200, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        n = 0;
        while (!mem_req_o && n < 20) begin @(posedge gclk); #1; n++; end
        chk("abort_req_seen", mem_req_o, 1);
        #3 grst_n = 1'b0;
        #1;
        chk("abort_req_drop", mem_req_o, 0);
        chk("abort_out_valid", out_valid_o, 0);
        chk("abort_in_ready", in_ready_o, 0);
        @(posedge gclk); @(posedge gclk);
        #3 grst_n = 1'b1; gnt_delay = 0;
        @(posedge gclk); #1;
        chk("abort_ready_back", in_ready_o, 1);
        issue(OP_ADD, 32'd5, 32'd6, 1'b0, 1'b1, 32'd11, 1'b0);
        drain();

`ifdef CORE_EXU_MUL_EN
        issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        n = 0;
        while (!out_valid_o && n < 100) begin @(posedge gclk); #1; n++; end
        chk("mul_latency", n, 33);
        drain();
        issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h4000_0000, 1'b0);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        drain();
`else
        issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 32'd1, 1'b0);
        @(posedge gclk); #1;
        chk("mul_as_add_latency", out_valid_o, 1);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
